ps2_keyscan: RTL
================

PS2_KEYSCAN -- requirements
Module: ps2_keyscan

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning received-byte FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter COUNT_W, default 8, meaning press_count width.
REQ-003 SHALL have parameter TIMEOUT, default 50000, meaning clk cycles without a ps2_clk falling edge before a partial frame is discarded.
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 resetn  input  1  asynchronous active-low reset.
REQ-006 ps2_clk  input  1  raw keyboard clock, asynchronous.
REQ-007 ps2_data  input  1  raw keyboard data, asynchronous.
REQ-008 code_valid  output  1  a make event is presented.
REQ-009 code_ready  input  1  downstream accepts the event; transfer when both are high.
REQ-010 key_code  output  8  scancode of the presented or last make event; feeds the scancode-to-ASCII lookup.
REQ-011 key_ext  output  1  key_code was preceded by E0.
REQ-012 key_pressed  output  1  a key is currently held.
REQ-013 press_count  output  COUNT_W  number of accepted make events, wraps modulo 2^COUNT_W.
REQ-014 frame_err  output  1  one-cycle pulse on a bad frame.
REQ-015 overflow  output  1  sticky; a good byte was dropped because the FIFO was full.

Function
REQ-016 SHALL pass ps2_clk and ps2_data through 2-flop synchronizers and detect a ps2_clk falling edge from the synchronized history, sampling data on that edge.
REQ-017 Frame: start bit 0, 8 data bits LSB first, odd parity, stop bit 1; a 4-bit bit counter runs 0..10 and returns to 0 after bit 10.
REQ-018 A frame SHALL be good only if start==0, stop==1, and XOR(data,parity)==1; a good byte SHALL be pushed into the FIFO the cycle after bit 10 is sampled.
REQ-019 A bad frame SHALL produce frame_err for exactly one cycle and push nothing.
REQ-020 If the bit counter is nonzero and TIMEOUT cycles pass with no falling edge, the counter SHALL return to 0 and no frame_err SHALL be raised.
REQ-021 Push when FIFO full SHALL drop the byte and set overflow, which holds until reset; simultaneous push and pop when full SHALL succeed.
REQ-022 Decoder FSM states: IDLE, EXT, BRK, HOLD; it pops one byte per cycle when the FIFO is non-empty and the state is not HOLD.
REQ-023 IDLE/EXT, byte E0: set ext flag, go to EXT.
REQ-024 IDLE/EXT, byte F0: go to BRK, keeping the ext flag.
REQ-025 BRK, any byte: clear key_pressed, clear ext, go to IDLE; no event is raised.
REQ-026 IDLE/EXT, other byte: if key_pressed==1 and byte==key_code and ext==key_ext (typematic repeat), it SHALL be discarded and the FSM goes to IDLE; otherwise it SHALL load key_code and key_ext, set key_pressed, assert code_valid, and go to HOLD.
REQ-027 HOLD: code_valid stays high and key_code stays stable until code_ready; on the transfer cycle press_count increments, code_valid drops next cycle, ext clears, and the FSM goes to IDLE.
REQ-028 Latency SHALL be: stop-bit edge, then FIFO push at +1 cycle, then code_valid at +3 cycles at the earliest.
REQ-029 code_valid SHALL NOT depend combinationally on code_ready.

Reset
REQ-030 On resetn low, immediately: bit counter 0, FIFO empty, FSM IDLE, code_valid 0, key_code 8'h00, key_ext 0, key_pressed 0, press_count 0, frame_err 0, overflow 0, synchronizers 1.
REQ-031 Reset mid-frame or in HOLD SHALL abandon the frame or event with no residual output after release.

Structure
REQ-032 The FSM state encoding and the constants 8'hE0 and 8'hF0 SHALL live in a shared package ps2_pkg.
REQ-033 The FIFO SHALL be one sub-module, sync_fifo, parameterized by width and depth.

Verification
REQ-034 Frame 1C with good parity and code_ready=1 -> code_valid one cycle, key_code=1C, press_count=1, key_pressed=1.
REQ-035 Sequence 1C,1C,1C,F0,1C -> one event only, press_count=1, key_pressed=0 at end.
REQ-036 Frame 32 with parity flipped -> frame_err pulse, no event; a following good 21 -> event key_code=21.
REQ-037 E0,75 -> event key_code=75, key_ext=1; then E0,F0,75 -> key_pressed=0.
REQ-038 code_ready=0 while 12 good distinct frames arrive -> first event held stable, overflow=1 after the 10th byte, bytes 2..9 delivered in order when ready rises.
REQ-039 Stop after 5 bits, wait TIMEOUT+10 cycles, then full frame 24 -> event key_code=24, no frame_err; resetn pulse mid-frame -> all outputs at reset values.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared decoder state encoding, PS/2 prefix byte constants and the frame check.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXT  = 2'd1,
    ST_BRK  = 2'd2,
    ST_HOLD = 2'd3
  } dec_state_t;

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  // Good frame: start low, stop high, odd parity over data plus parity bit.
  function automatic logic frame_ok(input logic start, input logic [7:0] data,
                                    input logic parity, input logic stop);
    return !start && stop && (^{data, parity});
  endfunction

endpackage

// File: rtl/ps2_keyscan_if.sv
// Make-event handshake between the keyscan decoder and its consumer.
interface ps2_keyscan_if;
  // A transfer happens on a rising clk edge where code_valid && code_ready are both high;
  // while code_valid is high and code_ready is low, key_code and key_ext stay stable.
  logic       code_valid;
  logic       code_ready;
  logic [7:0] key_code;
  logic       key_ext;

  modport master (output code_valid, output key_code, output key_ext, input code_ready);
  modport slave  (input code_valid, input key_code, input key_ext, output code_ready);
endinterface

// File: rtl/ps2_keyscan_fifo.sv
// Show-ahead synchronous FIFO; a write while full only lands if a read happens the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_ok;
  logic             rd_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ps2_keyscan.sv
// PS/2 keyboard receiver: synchronize, deframe, buffer, and decode make/break/E0 sequences.
module ps2_keyscan
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int COUNT_W    = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  ps2_keyscan_if.master      evt,
  output logic               key_pressed,
  output logic [COUNT_W-1:0] press_count,
  output logic               frame_err,
  output logic               overflow,
  output dec_state_t         dbg_state
);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [2:0]    clk_sh;
  logic [1:0]    dat_sh;
  logic          fall;
  logic          bit_in;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic [TW-1:0] idle_cnt;
  logic          push;
  logic [7:0]    push_data;
  logic          pop;
  logic [7:0]    byte_q;
  logic          fifo_full;
  logic          fifo_empty;
  dec_state_t    state;
  logic          ext;
  logic          valid_q;
  logic [7:0]    code_q;
  logic          kext_q;

  // clk_sh[1:0] is the 2-flop synchronizer, clk_sh[2] the history used for edge detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_sh <= '1;
      dat_sh <= '1;
    end else begin
      clk_sh <= {clk_sh[1:0], ps2_clk};
      dat_sh <= {dat_sh[0], ps2_data};
    end
  end

  assign fall   = clk_sh[2] & ~clk_sh[1];
  assign bit_in = dat_sh[1];

  // Bits 0..9 shift in from the top, so start ends up in shreg[0] and parity in shreg[9].
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      idle_cnt  <= '0;
      push      <= 1'b0;
      push_data <= '0;
      frame_err <= 1'b0;
    end else begin
      push      <= 1'b0;
      frame_err <= 1'b0;
      if (fall) begin
        idle_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= '0;
          if (frame_ok(shreg[0], shreg[8:1], shreg[9], bit_in)) begin
            push      <= 1'b1;
            push_data <= shreg[8:1];
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          shreg   <= {bit_in, shreg[9:1]};
        end
      end else if (bit_cnt != 4'd0) begin
        if (idle_cnt == TW'(TIMEOUT - 1)) begin
          bit_cnt  <= '0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + TW'(1);
        end
      end
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (push),
    .wr_data (push_data),
    .rd_en   (pop),
    .rd_data (byte_q),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign pop = !fifo_empty && (state != ST_HOLD);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) overflow <= 1'b0;
    else if (push && fifo_full && !pop) overflow <= 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      ext         <= 1'b0;
      valid_q     <= 1'b0;
      code_q      <= '0;
      kext_q      <= 1'b0;
      key_pressed <= 1'b0;
      press_count <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_EXT: if (pop) begin
          if (byte_q == CODE_EXT) begin
            ext   <= 1'b1;
            state <= ST_EXT;
          end else if (byte_q == CODE_BRK) begin
            state <= ST_BRK;
          end else if (key_pressed && byte_q == code_q && ext == kext_q) begin
            // Typematic repeat of the held key: swallow it.
            ext   <= 1'b0;
            state <= ST_IDLE;
          end else begin
            code_q      <= byte_q;
            kext_q      <= ext;
            key_pressed <= 1'b1;
            valid_q     <= 1'b1;
            state       <= ST_HOLD;
          end
        end
        ST_BRK: if (pop) begin
          key_pressed <= 1'b0;
          ext         <= 1'b0;
          state       <= ST_IDLE;
        end
        ST_HOLD: if (evt.code_ready) begin
          press_count <= press_count + COUNT_W'(1);
          valid_q     <= 1'b0;
          ext         <= 1'b0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign evt.code_valid = valid_q;
  assign evt.key_code   = code_q;
  assign evt.key_ext    = kext_q;
  assign dbg_state      = state;
endmodule
